spr_core_mc: RTL and testbench

//  Multi-channel successor of the single-channel SPR core. Averages prev+curr per sub-pixel channel, then either applies a selected

---
 rtl/spr_core_mc_if.sv | 37 +++
 rtl/spr_core_mc.sv | 125 ++++++++++++
 tb/tb_spr_core_mc.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/spr_core_mc_if.sv
// spr_core_mc_if: sample, classification, gain and result bundle of the multi-channel SPR core
interface spr_core_mc_if #(
  parameter int NCH    = 3,
  parameter int IN_W   = 12,
  parameter int OUT_W  = 11,
  parameter int GAIN_W = 14,
  parameter int CNT_W  = 16
);
  logic                   i_hs;
  logic                   i_vs;
  logic                   in_valid;
  logic                   mode_sep;
  logic                   is_border;
  logic                   is_original;
  logic [3:0]             is_edge;
  logic [GAIN_W-1:0]      gain_border;
  logic [GAIN_W-1:0]      gain_e2;
  logic [GAIN_W-1:0]      gain_e3;
  logic [GAIN_W-1:0]      gain_e4;
  logic [GAIN_W-1:0]      gain_e5;
  logic [NCH*IN_W-1:0]    prev;
  logic [NCH*IN_W-1:0]    curr;
  logic                   out_valid;
  logic [NCH*OUT_W-1:0]   core_out;
  logic                   sat_any;
  logic [CNT_W-1:0]       frame_sat_cnt;
  modport master (
    output i_hs, i_vs, in_valid, mode_sep, is_border, is_original, is_edge,
           gain_border, gain_e2, gain_e3, gain_e4, gain_e5, prev, curr,
    input  out_valid, core_out, sat_any, frame_sat_cnt
  );
  modport slave (
    input  i_hs, i_vs, in_valid, mode_sep, is_border, is_original, is_edge,
           gain_border, gain_e2, gain_e3, gain_e4, gain_e5, prev, curr,
    output out_valid, core_out, sat_any, frame_sat_cnt
  );
endinterface

// File: rtl/spr_core_mc.sv
// spr_core_mc: per-channel prev+curr averaging with classified gain or quarter-sum, saturation and frame clip report
module spr_core_mc #(
  parameter int NCH    = 3,
  parameter int IN_W   = 12,
  parameter int OUT_W  = 11,
  parameter int GAIN_W = 14,
  parameter int FRAC   = 8,
  parameter int ROUND  = 1,
  parameter int CNT_W  = 16
) (
  input logic          clk,
  input logic          rst,
  spr_core_mc_if.slave bus
);
  localparam int S_W = IN_W + 1;
  localparam int P_W = S_W + GAIN_W;
  localparam int N_W = $clog2(NCH + 1);
  localparam logic [OUT_W-1:0] MAX_OUT = '1;
  localparam logic [P_W:0] R1 = (P_W+1)'(ROUND != 0 ? 2 ** (FRAC - 1) : 0);
  localparam logic [S_W:0] R2 = (S_W+1)'(ROUND != 0 ? 2 : 0);

  logic                 blank;
  logic [GAIN_W-1:0]    gain0, gain1;
  logic                 spec0, spec1, v1;
  logic [NCH*S_W-1:0]   sum1;
  logic [NCH-1:0]       clip;
  logic [NCH*OUT_W-1:0] res;
  logic [N_W-1:0]       nclip, nsat;
  logic [CNT_W:0]       run_sum;
  logic [CNT_W-1:0]     run, run_nx;
  logic                 vs_d;

  assign blank = !(bus.i_hs && bus.i_vs);

  // gain/special select: border beats edges, edges by fixed priority, otherwise quarter-sum
  always_comb begin
    gain0 = !bus.mode_sep   ? bus.gain_e2 :
            bus.is_border   ? bus.gain_border :
            bus.is_edge[3]  ? bus.gain_e2 :
            bus.is_edge[2]  ? bus.gain_e3 :
            bus.is_edge[1]  ? bus.gain_e4 :
            bus.is_edge[0]  ? bus.gain_e5 : bus.gain_e2;
    spec0 = bus.mode_sep ? (bus.is_border || |bus.is_edge) : bus.is_original;
  end

  // stage 1: channel sums and selected gain, captured only on valid samples
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      v1    <= 1'b0;
      sum1  <= '0;
      gain1 <= '0;
      spec1 <= 1'b0;
    end else if (blank) begin
      v1    <= 1'b0;
      sum1  <= '0;
      gain1 <= '0;
      spec1 <= 1'b0;
    end else begin
      v1 <= bus.in_valid;
      if (bus.in_valid) begin
        gain1 <= gain0;
        spec1 <= spec0;
        for (int c = 0; c < NCH; c++)
          sum1[c*S_W +: S_W] <= S_W'(bus.prev[c*IN_W +: IN_W]) + S_W'(bus.curr[c*IN_W +: IN_W]);
      end
    end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [S_W-1:0] s;
    logic [P_W:0]   p, v;
    assign s = sum1[c*S_W +: S_W];
    assign p = (P_W+1)'(s) * (P_W+1)'(gain1);
    assign v = spec1 ? (p + R1) >> FRAC : (P_W+1)'(({1'b0, s} + R2) >> 2);
    assign clip[c] = v > (P_W+1)'(MAX_OUT);
    assign res[c*OUT_W +: OUT_W] = clip[c] ? MAX_OUT : v[OUT_W-1:0];
  end

  // number of channels clipped in the stage-2 result
  always_comb begin
    nclip = '0;
    for (int c = 0; c < NCH; c++) nclip = nclip + N_W'(clip[c]);
  end

  // stage 2: registered results and clip summary
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.core_out  <= '0;
      bus.sat_any   <= 1'b0;
      nsat          <= '0;
    end else if (blank) begin
      bus.out_valid <= 1'b0;
      bus.core_out  <= '0;
      bus.sat_any   <= 1'b0;
      nsat          <= '0;
    end else begin
      bus.out_valid <= v1;
      if (v1) begin
        bus.core_out <= res;
        bus.sat_any  <= |clip;
        nsat         <= nclip;
      end
    end

  // running clip count including the result visible this cycle, saturating
  always_comb begin
    run_sum = {1'b0, run} + (CNT_W+1)'(bus.out_valid ? nsat : '0);
    run_nx  = run_sum[CNT_W] ? '1 : run_sum[CNT_W-1:0];
  end

  // frame report on the i_vs falling edge; the running count survives line blanking
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      vs_d              <= 1'b0;
      run               <= '0;
      bus.frame_sat_cnt <= '0;
    end else begin
      vs_d <= bus.i_vs;
      if (vs_d && !bus.i_vs) begin
        bus.frame_sat_cnt <= run_nx;
        run               <= '0;
      end else
        run <= run_nx;
    end
endmodule

// File: tb/tb_spr_core_mc.sv
// tb_spr_core_mc: scoreboard bench driving a rounding and a truncating core with the same directed vectors
module tb_spr_core_mc;
  typedef struct {
    logic [32:0] o1;
    logic        s1;
    logic [32:0] o0;
    logic        s0;
    int          cyc;
  } exp_t;

  logic clk = 0, rst = 1;
  logic hs, vs, valid, ms, bd, org;
  logic [3:0]  ed;
  logic [13:0] gb, ge2, ge3, ge4, ge5;
  logic [35:0] pv, cv;
  int   cyc = 0, errors = 0, checks = 0;
  exp_t sb[$];

  spr_core_mc_if b0 ();
  spr_core_mc_if b1 ();

  assign b0.i_hs = hs;          assign b1.i_hs = hs;
  assign b0.i_vs = vs;          assign b1.i_vs = vs;
  assign b0.in_valid = valid;   assign b1.in_valid = valid;
  assign b0.mode_sep = ms;      assign b1.mode_sep = ms;
  assign b0.is_border = bd;     assign b1.is_border = bd;
  assign b0.is_original = org;  assign b1.is_original = org;
  assign b0.is_edge = ed;       assign b1.is_edge = ed;
  assign b0.gain_border = gb;   assign b1.gain_border = gb;
  assign b0.gain_e2 = ge2;      assign b1.gain_e2 = ge2;
  assign b0.gain_e3 = ge3;      assign b1.gain_e3 = ge3;
  assign b0.gain_e4 = ge4;      assign b1.gain_e4 = ge4;
  assign b0.gain_e5 = ge5;      assign b1.gain_e5 = ge5;
  assign b0.prev = pv;          assign b1.prev = pv;
  assign b0.curr = cv;          assign b1.curr = cv;

  spr_core_mc #(.ROUND(1)) u0 (.clk(clk), .rst(rst), .bus(b0));
  spr_core_mc #(.ROUND(0)) u1 (.clk(clk), .rst(rst), .bus(b1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // monitor: every presented result is matched against the oldest expectation
  always @(negedge clk)
    if (!rst && (b0.out_valid || b1.out_valid)) begin
      if (sb.size() == 0) chk("unexpected_out", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        chk("latency", cyc, e.cyc);
        chk("valid_r1", b0.out_valid, 1);
        chk("valid_r0", b1.out_valid, 1);
        chk("out_r1", b0.core_out, e.o1);
        chk("sat_r1", b0.sat_any, e.s1);
        chk("out_r0", b1.core_out, e.o0);
        chk("sat_r0", b1.sat_any, e.s0);
      end
    end

  task automatic send(input bit ms_, bd_, org_, input logic [3:0] ed_, input logic [13:0] gb_,
                      input logic [35:0] p_, c_, input logic [32:0] e1, input bit s1,
                      input logic [32:0] e0, input bit s0, input bit push = 1);
    @(posedge clk); #1;
    valid = 1; ms = ms_; bd = bd_; org = org_; ed = ed_; gb = gb_; pv = p_; cv = c_;
    if (push) sb.push_back('{o1: e1, s1: s1, o0: e0, s0: s0, cyc: cyc + 2});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      valid = 0;
    end
  endtask

  task automatic vs_fall(input int e1, input int e0);
    @(posedge clk); #1;
    valid = 0; vs = 0;
    @(posedge clk);
    @(negedge clk);
    chk("frame_cnt_r1", b0.frame_sat_cnt, e1);
    chk("frame_cnt_r0", b1.frame_sat_cnt, e0);
    @(posedge clk); #1;
    vs = 1;
  endtask

  task automatic clip_px();
    send(1, 1, 0, 4'h0, 14'h0100, {3{12'hFFF}}, {3{12'hFFF}}, {3{11'h7FF}}, 1, {3{11'h7FF}}, 1);
  endtask

  task automatic edge_px();
    send(1, 0, 0, 4'b0110, 14'h0100, {3{12'h100}}, {3{12'h100}}, {3{11'h100}}, 0, {3{11'h100}}, 0);
  endtask

  initial begin
    hs = 1; vs = 1; valid = 0; ms = 0; bd = 0; org = 0; ed = 0; gb = 0;
    ge2 = 14'h0180; ge3 = 14'h0080; ge4 = 14'h0200; ge5 = 14'h0040;
    pv = 0; cv = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", b0.out_valid, 0);
    chk("rst_out", b0.core_out, 0);
    chk("rst_sat", b0.sat_any, 0);
    chk("rst_frame", b0.frame_sat_cnt, 0);
    rst = 0;
    // frame 1: function vectors back to back
    send(0, 0, 0, 4'h0, 14'h0100, {3{12'h7FF}}, {3{12'h7FF}}, {3{11'h400}}, 0, {3{11'h3FF}}, 0);
    clip_px();
    edge_px();
    send(1, 1, 0, 4'h0, 14'h0001, {3{12'h040}}, {3{12'h040}}, {3{11'h001}}, 0, {3{11'h000}}, 0);
    send(0, 0, 0, 4'h0, 14'h0100, {3{12'hFFF}}, {3{12'hFFF}}, {3{11'h7FF}}, 1, {3{11'h7FF}}, 0);
    send(0, 0, 1, 4'h0, 14'h0100, {12'h001, 12'h200, 12'h010}, {12'h000, 12'h200, 12'h011},
         {11'h002, 11'h600, 11'h032}, 0, {11'h001, 11'h600, 11'h031}, 0);
    send(1, 0, 0, 4'h0, 14'h0100, {3{12'h005}}, {3{12'h005}}, {3{11'h003}}, 0, {3{11'h002}}, 0);
    send(1, 0, 0, 4'b0001, 14'h0100, {3{12'h400}}, {3{12'h400}}, {3{11'h200}}, 0, {3{11'h200}}, 0);
    send(1, 1, 0, 4'hF, 14'h0200, {3{12'h100}}, {3{12'h100}}, {3{11'h400}}, 0, {3{11'h400}}, 0);
    idle(1);
    // valid gaps and a one-cycle line blank that swallows a clipping sample
    edge_px();
    idle(1);
    send(1, 1, 0, 4'h0, 14'h0100, {3{12'hFFF}}, {3{12'hFFF}}, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    valid = 0; hs = 0;
    @(posedge clk); #1;
    hs = 1;
    @(negedge clk);
    chk("blank_valid_r1", b0.out_valid, 0);
    chk("blank_out_r1", b0.core_out, 0);
    chk("blank_valid_r0", b1.out_valid, 0);
    chk("blank_out_r0", b1.core_out, 0);
    edge_px();
    idle(1);
    vs_fall(6, 3);
    // frame 2: five clipped pixels, last one lands in the reporting cycle
    repeat (5) clip_px();
    idle(1);
    vs_fall(15, 15);
    // frame 3: running count must have restarted from zero
    edge_px();
    idle(1);
    vs_fall(0, 0);
    // frame 4: reset mid-frame discards earlier clips and the last report
    clip_px();
    clip_px();
    idle(3);
    @(posedge clk); #1;
    rst = 1;
    #1;
    chk("midrst_frame_r1", b0.frame_sat_cnt, 0);
    chk("midrst_frame_r0", b1.frame_sat_cnt, 0);
    chk("midrst_valid", b0.out_valid, 0);
    chk("midrst_out", b0.core_out, 0);
    @(negedge clk);
    rst = 0;
    clip_px();
    idle(1);
    vs_fall(3, 3);
    idle(3);
    chk("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
